add_seq_arb: RTL and testbench
==============================

Name: add_seq_arb

Overview:
- Bit-serial sequencer and round-robin arbiter that shares one registered 1-bit full adder (the `add` block: a, b, c -> sum, carry) among NUM_REQ requesters.
- Accepts one WIDTH-bit addition at a time, steps it through the full adder LSB-first with the carry fed back, and returns the sum and carry-out over a valid/ready response channel.
- Sits between the requesters and the `add` instance.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- WIDTH, 8, operand width in bits (>=2)
- IDW, $clog2(NUM_REQ), width of rsp_id

Ports:
- clk  in  1  clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid; held until the matching req_ready
- req_ready  out  NUM_REQ  one-hot grant/accept strobe
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at slice [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_cin  in  NUM_REQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_sum  out  WIDTH  sum
- rsp_cout  out  1  carry-out
- fa_a, fa_b, fa_c  out  1 each  drive the full adder a, b, c
- fa_sum, fa_carry  in  1 each  full adder registered outputs (1-cycle latency)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, fa_*, busy.
  - Operand, sum and bit-index registers are cleared.
  - Round-robin pointer last_grant is set to NUM_REQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded and no response is produced for it.
- FSM states: IDLE, RUN, DRAIN, RESP.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching upward from last_grant+1 and wrapping.
  - req_ready[g] is driven combinationally high for that single cycle; the handshake completes in that cycle.
  - Latch req_a[g], req_b[g], req_cin[g] and g; set last_grant=g; set bit index k=0; go to RUN.
  - req_ready is 0 in every other state and cycle.
- RUN (WIDTH cycles, k = 0..WIDTH-1):
  - Drive fa_a=A[k], fa_b=B[k], fa_c = (k==0) ? cin : fa_carry.
  - For k>=1, capture fa_sum into sum[k-1] on the same edge.
  - After the cycle with k=WIDTH-1, go to DRAIN.
- DRAIN (1 cycle):
  - fa_* driven 0.
  - Capture fa_sum into sum[WIDTH-1] and fa_carry into cout; go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are registered and held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready, go to IDLE next cycle. No new grant is made in that same cycle.
- Latency: with the accept in cycle T, rsp_valid first rises in cycle T+WIDTH+2.
- Throughput: one operation per WIDTH+3 cycles minimum.
- Outside RUN, fa_a, fa_b and fa_c are 0.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, modulo 2^(WIDTH+1).
- Boundary cases:
  - A requester dropping req_valid before its grant is a protocol violation and is not checked.
  - A requester that is not granted keeps waiting; the round-robin pointer bounds its wait to NUM_REQ-1 operations.
  - rsp_ready high outside RESP is ignored.
  - Requests arriving while busy are not accepted until IDLE.

Optional Feature:
- Macro ADD_SEQ_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and last_grant is unused.
- Undefined (default): round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=2'b11 -> all outputs 0 and no req_ready; release -> req_ready=2'b01 in the first IDLE cycle.
- Single op, WIDTH=8: req0 a=0x3C, b=0x0F, cin=0 -> rsp_sum=0x4B, rsp_cout=0, rsp_id=0, rsp_valid exactly 10 cycles after accept; fa_c sequence matches the ripple carries.
- Carry-out: a=0xFF, b=0x01, cin=1 -> rsp_sum=0x01, rsp_cout=1; a=0x00, b=0x00, cin=1 -> rsp_sum=0x01, rsp_cout=0.
- Contention: req_valid=2'b11 held for 4 ops -> rsp_id sequence 0,1,0,1 (with ADD_SEQ_ARB_FIXED_PRIO_EN: 0,0,0,0).
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_sum/rsp_id stable, req_ready stays 0; after rsp_ready=1, next grant occurs one cycle later in IDLE.
- Reset mid-RUN at k=3 -> outputs go to 0 immediately (asynchronously) with no rsp_valid; after release the still-valid req0 is re-accepted and returns the correct sum.

Source files
------------

// File: rtl/add_seq_arb.sv
// ---------------------------------------------------------------------------
// add_seq_arb
//
// Bit-serial sequencer and arbiter that shares one registered 1-bit full
// adder among NUM_REQ requesters. One WIDTH-bit addition is accepted at a
// time, stepped through the adder LSB-first with the carry fed back, and the
// sum plus carry-out are returned over a valid/ready response channel.
//
// Configuration macro:
//   ADD_SEQ_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin starting at requester 0
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   req_valid   in   [NUM_REQ]        per-requester request valid
//   req_ready   out  [NUM_REQ]        one-hot accept strobe (IDLE only)
//   req_a       in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       in   [NUM_REQ*WIDTH]  operand B, same packing
//   req_cin     in   [NUM_REQ]        carry-in per requester
//   rsp_valid   out  result valid
//   rsp_ready   in   result accepted
//   rsp_id      out  [IDW]            owner of the result
//   rsp_sum     out  [WIDTH]          sum
//   rsp_cout    out  carry-out
//   fa_a/b/c    out  full adder inputs
//   fa_sum      in   full adder registered sum
//   fa_carry    in   full adder registered carry
//   busy        out  high whenever not IDLE
// ---------------------------------------------------------------------------
module add_seq_arb #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     fa_a,
    output logic                     fa_b,
    output logic                     fa_c,
    input  logic                     fa_sum,
    input  logic                     fa_carry,
    output logic                     busy
);

    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cin_q, cin_d;
    logic               cout_q, cout_d;
    logic [KW-1:0]      bitIdx_q, bitIdx_d;
    logic [IDW-1:0]     id_q, id_d;

    logic               anyValid;
    logic [IDW-1:0]     grantIdx;
    logic [WIDTH-1:0]   selA;
    logic [WIDTH-1:0]   selB;
    logic               selCin;

`ifndef ADD_SEQ_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     lastGrant_q, lastGrant_d;
    logic [IDW-1:0]     candIdx;
`endif

    // Pick the winning requester and mux its operands. The search loop runs
    // from lowest to highest priority so the last hit (highest priority)
    // overwrites earlier ones, which avoids a separate "found" flag.
    always_comb begin
        anyValid = 1'b0;
        grantIdx = '0;
        selA     = '0;
        selB     = '0;
        selCin   = 1'b0;
`ifdef ADD_SEQ_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[IDW'(i)]) begin
                anyValid = 1'b1;
                grantIdx = IDW'(i);
            end
        end
`else
        candIdx = '0;
        // Offset NUM_REQ wraps back to lastGrant itself (lowest priority);
        // offset 1 is the requester just after it (highest priority).
        for (int i = NUM_REQ; i >= 1; i--) begin
            candIdx = IDW'((int'(lastGrant_q) + i) % NUM_REQ);
            if (req_valid[candIdx]) begin
                anyValid = 1'b1;
                grantIdx = candIdx;
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                selA   = req_a[i*WIDTH +: WIDTH];
                selB   = req_b[i*WIDTH +: WIDTH];
                selCin = req_cin[i];
            end
        end
    end

    // Next-state and output logic. The sum register is a right shift
    // register: each adder result enters at the MSB, so after exactly WIDTH
    // shifts (WIDTH-1 in RUN, one in DRAIN) bit k of the sum sits at index k.
    // req_ready is gated by reset so no grant is shown while reset is held.
    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        sum_d       = sum_q;
        cin_d       = cin_q;
        cout_d      = cout_q;
        bitIdx_d    = bitIdx_q;
        id_d        = id_q;
`ifndef ADD_SEQ_ARB_FIXED_PRIO_EN
        lastGrant_d = lastGrant_q;
`endif
        req_ready   = '0;
        rsp_valid   = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_c        = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (anyValid && reset) begin
                    req_ready   = NUM_REQ'(1) << grantIdx;
                    opA_d       = selA;
                    opB_d       = selB;
                    cin_d       = selCin;
                    id_d        = grantIdx;
`ifndef ADD_SEQ_ARB_FIXED_PRIO_EN
                    lastGrant_d = grantIdx;
`endif
                    bitIdx_d    = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                fa_a = opA_q[bitIdx_q];
                fa_b = opB_q[bitIdx_q];
                fa_c = (bitIdx_q == '0) ? cin_q : fa_carry;
                // Adder output lags one cycle, so bit k-1 arrives during k.
                if (bitIdx_q != '0) begin
                    sum_d = {fa_sum, sum_q[WIDTH-1:1]};
                end
                if (bitIdx_q == KW'(WIDTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    bitIdx_d = bitIdx_q + KW'(1);
                end
            end
            DRAIN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                cout_d  = fa_carry;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight
    // and points the round-robin pointer at the last requester so that
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            sum_q       <= '0;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
            bitIdx_q    <= '0;
            id_q        <= '0;
`ifndef ADD_SEQ_ARB_FIXED_PRIO_EN
            lastGrant_q <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            sum_q       <= sum_d;
            cin_q       <= cin_d;
            cout_q      <= cout_d;
            bitIdx_q    <= bitIdx_d;
            id_q        <= id_d;
`ifndef ADD_SEQ_ARB_FIXED_PRIO_EN
            lastGrant_q <= lastGrant_d;
`endif
        end
    end

    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;

endmodule

// File: tb/tb_add_seq_arb.sv
// ---------------------------------------------------------------------------
// tb_add_seq_arb
//
// Directed bench for add_seq_arb with NUM_REQ=2, WIDTH=8. A registered 1-bit
// full adder model stands in for the shared add block. Inputs are driven and
// outputs sampled shortly after the rising edge.
// ---------------------------------------------------------------------------
module tb_add_seq_arb;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;
    logic        fa_a, fa_b, fa_c;
    logic        fa_sum, fa_carry;
    logic        busy;

    int checks = 0;
    int errors = 0;

    add_seq_arb #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_c      (fa_c),
        .fa_sum    (fa_sum),
        .fa_carry  (fa_carry),
        .busy      (busy)
    );

    // 100 MHz-style clock with a 10-unit period.
    always #5 clk = ~clk;

    // Registered full adder with one cycle of latency, like the add block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fa_sum   <= 1'b0;
            fa_carry <= 1'b0;
        end else begin
            fa_sum   <= fa_a ^ fa_b ^ fa_c;
            fa_carry <= (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
        end
    end

    // Load one requester's operands.
    task automatic loadReq(input logic [0:0] r, input logic [7:0] a,
                           input logic [7:0] b, input logic c);
        if (r == 1'b0) begin
            req_a[7:0] = a;
            req_b[7:0] = b;
        end else begin
            req_a[15:8] = a;
            req_b[15:8] = b;
        end
        req_cin[r] = c;
    endtask

    // Run one operation end to end and acknowledge the response. lat is the
    // number of cycles from the accept cycle to the first rsp_valid cycle,
    // or -1 if the grant never appeared.
    task automatic issueOp(input logic [0:0] r, input logic [7:0] a,
                           input logic [7:0] b, input logic c,
                           output int lat, output logic [7:0] s,
                           output logic co, output logic [0:0] id);
        int n;
        loadReq(r, a, b, c);
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (n >= 40) lat = -1;
        s  = rsp_sum;
        co = rsp_cout;
        id = rsp_id;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        req_valid = 2'b11;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        req_cin   = 2'b00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        checks++;
        if ({rsp_valid, busy, fa_a, fa_b, fa_c, rsp_cout} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {rsp_valid, busy, fa_a, fa_b, fa_c, rsp_cout});
        end
        checks++;
        if (rsp_sum !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_sum: got %h expected 00", rsp_sum);
        end
        checks++;
        if (rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_id: got %b expected 0", rsp_id);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single_op;
        int         n;
        int         cyc;
        logic [7:0] faTrace;
        logic [7:0] expTrace;
        expTrace = 8'h78;
        faTrace  = 8'h00;
        loadReq(1'b0, 8'h3C, 8'h0F, 1'b0);
        req_valid[0] = 1'b1;
        #1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        cyc = 1;
        for (int k = 0; k < 8; k++) begin
            faTrace = {fa_c, faTrace[7:1]};
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if ({fa_a, fa_b, fa_c, busy, rsp_valid} !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL single_drain: got %b expected 00010",
                     {fa_a, fa_b, fa_c, busy, rsp_valid});
        end
        @(posedge clk); #1;
        cyc++;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency: rsp_valid %b at cycle %0d, expected 1",
                     rsp_valid, cyc);
        end
        checks++;
        if (faTrace !== expTrace) begin
            errors++;
            $display("[TB] FAIL single_fa_c_trace: got %b expected %b", faTrace, expTrace);
        end
        checks++;
        if ({rsp_cout, rsp_sum} !== 9'h04B) begin
            errors++;
            $display("[TB] FAIL single_sum: got %h expected 04b", {rsp_cout, rsp_sum});
        end
        checks++;
        if (rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_id: got %b expected 0", rsp_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_carry_out;
        int         lat;
        logic [7:0] s;
        logic       co;
        logic [0:0] id;
        issueOp(1'b0, 8'hFF, 8'h01, 1'b1, lat, s, co, id);
        checks++;
        if ({co, s} !== 9'h101 || lat !== 10) begin
            errors++;
            $display("[TB] FAIL carry_ff_01_1: got %h lat %0d expected 101 lat 10", {co, s}, lat);
        end
        issueOp(1'b0, 8'h00, 8'h00, 1'b1, lat, s, co, id);
        checks++;
        if ({co, s} !== 9'h001 || lat !== 10) begin
            errors++;
            $display("[TB] FAIL carry_00_00_1: got %h lat %0d expected 001 lat 10", {co, s}, lat);
        end
        issueOp(1'b1, 8'hA5, 8'h5A, 1'b0, lat, s, co, id);
        checks++;
        if ({co, s} !== 9'h0FF || lat !== 10) begin
            errors++;
            $display("[TB] FAIL carry_a5_5a_0: got %h lat %0d expected 0ff lat 10", {co, s}, lat);
        end
        checks++;
        if (id !== 1'b1) begin
            errors++;
            $display("[TB] FAIL carry_req1_id: got %b expected 1", id);
        end
    endtask

    task automatic test_contention;
        logic [3:0] expIds;
        logic [8:0] expRes;
        int         n;
`ifdef ADD_SEQ_ARB_FIXED_PRIO_EN
        expIds = 4'b0000;
`else
        expIds = 4'b1010;
`endif
        loadReq(1'b0, 8'h10, 8'h01, 1'b0);
        loadReq(1'b1, 8'h20, 8'h02, 1'b1);
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if ({rsp_valid, rsp_id} !== {1'b1, expIds[op]}) begin
                errors++;
                $display("[TB] FAIL contention_id op%0d: got valid %b id %b expected valid 1 id %b",
                         op, rsp_valid, rsp_id, expIds[op]);
            end
            expRes = (expIds[op] == 1'b0) ? 9'h011 : 9'h023;
            checks++;
            if ({rsp_cout, rsp_sum} !== expRes) begin
                errors++;
                $display("[TB] FAIL contention_sum op%0d: got %h expected %h",
                         op, {rsp_cout, rsp_sum}, expRes);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            if (op == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_backpressure;
        int n;
        int lat;
        loadReq(1'b1, 8'h12, 8'h34, 1'b0);
        req_valid[1] = 1'b1;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        loadReq(1'b0, 8'h80, 8'h80, 1'b0);
        req_valid[0] = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_cout, rsp_sum, req_ready} !== {1'b1, 1'b1, 1'b0, 8'h46, 2'b00}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold c%0d: got v%b id%b co%b sum %h rdy %b expected v1 id1 co0 sum 46 rdy 00",
                         c, rsp_valid, rsp_id, rsp_cout, rsp_sum, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL backpressure_no_grant_on_ack: got %b expected 00", req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL backpressure_next_grant: got %b expected 001", {rsp_valid, req_ready});
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({rsp_cout, rsp_sum, rsp_id} !== {9'h100, 1'b0} || lat !== 10) begin
            errors++;
            $display("[TB] FAIL backpressure_second_op: got %h id %b lat %0d expected 100 id 0 lat 10",
                     {rsp_cout, rsp_sum}, rsp_id, lat);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int n;
        int lat;
        loadReq(1'b0, 8'h55, 8'h2A, 1'b1);
        req_valid[0] = 1'b1;
        #1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, fa_a, fa_b} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL midrun_k3_drive: got %b expected 101", {busy, fa_a, fa_b});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, req_ready, fa_a, fa_b, fa_c, rsp_sum} !== 15'b0) begin
            errors++;
            $display("[TB] FAIL midrun_async_clear: got %b expected all zero",
                     {busy, rsp_valid, req_ready, fa_a, fa_b, fa_c, rsp_sum});
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrun_held_reset: got %b expected 0000", {rsp_valid, busy, req_ready});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midrun_regrant: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({rsp_cout, rsp_sum, rsp_id} !== {9'h080, 1'b0} || lat !== 10) begin
            errors++;
            $display("[TB] FAIL midrun_result: got %h id %b lat %0d expected 080 id 0 lat 10",
                     {rsp_cout, rsp_sum}, rsp_id, lat);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Scenarios run in a fixed order: the carry test ends on requester 1 so
    // the round-robin contention sequence starts from requester 0.
    initial begin
        test_reset();
        test_single_op();
        test_carry_out();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
